fir_seq_ctrl: RTL

- Time-multiplexed FIR sequencer. It owns the sample delay line and a coefficient register file, and drives one shared multiply-accumulate unit through NTAPS taps per accepted sample.
- Replaces the parallel combinational tap sum with a sequenced, area-light datapath.
- Sits between the pin-level sample input and the output pins.
- Uses valid/ready handshakes on both sides and a runtime coefficient write port.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_seq_ctrl_if.sv | 32 +++
 rtl/fir_mac_unit.sv | 30 +++
 rtl/fir_seq_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and default sizing for the time-multiplexed FIR sequencer.
package fir_pkg;

    localparam int NTAPS_D  = 4;
    localparam int DW_D     = 8;
    localparam int CW_D     = 8;
    localparam int SHIFT_D  = 2;
    localparam int OW_D     = 8;
    localparam int TAPW_D   = $clog2(NTAPS_D);
    localparam int ACCW_D   = DW_D + CW_D + TAPW_D;
    localparam int COEF_RST = 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Wide enough that NTAPS full-scale products can never overflow.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample input, coefficient write and result output handshakes of fir_seq_ctrl.
interface fir_seq_ctrl_if
    import fir_pkg::*;
#(
    parameter int DW   = DW_D,
    parameter int CW   = CW_D,
    parameter int OW   = OW_D,
    parameter int TAPW = TAPW_D
) ();

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            coef_we;
    logic            coef_ready;
    logic [TAPW-1:0] coef_addr;
    logic [CW-1:0]   coef_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, coef_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, coef_ready, out_valid, out_data
    );

endinterface

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate unit: registered accumulator with clear and enable.
module fir_mac_unit #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int ACCW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   x,
    input  logic [CW-1:0]   c,
    output logic [ACCW-1:0] acc
);

    logic [DW+CW-1:0] prod;

    assign prod = x * c;

    // NOTE: registered state is always written with <= so every flop samples
    // the pre-edge values of the others, regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Time-multiplexed FIR sequencer: delay line, coefficient file and MAC control.
// Define FIR_SAT_EN to clamp the output instead of truncating it.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_D,
    parameter int DW    = DW_D,
    parameter int CW    = CW_D,
    parameter int SHIFT = SHIFT_D,
    parameter int OW    = OW_D
) (
    input  logic          clk,
    input  logic          rst,
    fir_seq_ctrl_if.slave bus,
    output logic          busy
);

    localparam int TAPW = $clog2(NTAPS);
    localparam int ACCW = acc_width(DW, CW, NTAPS);

    state_t          state, state_nx;
    logic [DW-1:0]   x_q    [NTAPS];
    logic [CW-1:0]   coef_q [NTAPS];
    logic [TAPW-1:0] tap_q;
    logic            drain_q;
    logic [OW-1:0]   out_data_q;
    logic            out_valid_q;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] shifted;
    logic [OW-1:0]   result;
    logic            in_ready, coef_ready, mac_clr, mac_en, fin;
    logic            accept, coef_wr;

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        coef_ready = (state != MAC);
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        fin        = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    mac_clr  = 1'b1;
                    state_nx = MAC;
                end
            end
            // drain_q marks the extra cycle that reads back the final sum
            MAC: begin
                if (drain_q) begin
                    fin      = 1'b1;
                    state_nx = OUT;
                end else begin
                    mac_en = 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = bus.in_valid & in_ready;
    assign coef_wr = bus.coef_we & coef_ready;
    assign shifted = acc >> SHIFT;

`ifdef FIR_SAT_EN
    assign result = (|(shifted >> OW)) ? {OW{1'b1}} : OW'(shifted);
`else
    assign result = OW'(shifted);
`endif

    // NOTE: the delay line and coefficient file are reset explicitly because
    // a reset must discard history and restore the moving-average taps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tap_q       <= '0;
            drain_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= CW'(COEF_RST);
            end
        end else begin
            state <= state_nx;
            if (accept) begin
                x_q[0] <= bus.in_data;
                for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
                tap_q   <= '0;
                drain_q <= 1'b0;
            end else if (mac_en) begin
                tap_q   <= tap_q + 1'b1;
                drain_q <= (tap_q == TAPW'(NTAPS - 1));
            end else if (fin) begin
                drain_q <= 1'b0;
            end
            if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_data;
            if (fin) begin
                out_data_q  <= result;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    fir_mac_unit #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .x   (x_q[tap_q]),
        .c   (coef_q[tap_q]),
        .acc (acc)
    );

    assign bus.in_ready   = in_ready;
    assign bus.coef_ready = coef_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign busy           = (state != IDLE);

endmodule
